uart_baud_gen: RTL
==================

Name: uart_baud_gen

Overview:
Parametrised UART baud-rate generator that succeeds the fixed-table UART clock divider. It produces an oversampling tick from a runtime-programmable integer+fractional divisor and a bit tick every OVERSAMPLE ticks. It supports glitch-free divisor updates at period boundaries and a sync input that re-phases the bit tick to mid-bit for RX start-bit alignment. It is shared by UART TX (bit tick) and UART RX (oversample tick, sync).

Parameters:
CNT_WIDTH, 16, width of integer divisor and period counter
FRAC_BITS, 4, width of fractional divisor; fraction = i_div_frac / 2^FRAC_BITS
OVERSAMPLE, 16, oversample ticks per bit; power of two, >= 2
SYNC_TO_HALF, 1, 1: sync positions bit phase at half bit; 0: at bit start
RESET_DIV, 27, integer divisor active after reset (fraction 0); must be >= 2

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  synchronous active-low reset
i_en  input  1  generator enable
i_sync  input  1  single-cycle pulse; restart period and bit phase
i_div_load  input  1  single-cycle pulse; capture i_div_int/i_div_frac
i_div_int  input  CNT_WIDTH  integer divisor (cycles per oversample tick)
i_div_frac  input  FRAC_BITS  fractional divisor part
o_tick  output  1  oversample tick, one cycle wide
o_bit_tick  output  1  bit tick, one cycle wide, coincides with an o_tick
o_div_pending  output  1  captured divisor not yet applied

Behaviour:
- State: active divisor (int, frac), pending divisor + pending flag, down-counter r_cnt (CNT_WIDTH), frac accumulator r_acc (FRAC_BITS), oversample counter r_os (log2 OVERSAMPLE).
- Effective int divisor = max(div_int, 2); values 0/1 clamp to 2 at capture.
- o_tick = i_en & (r_cnt == 0); o_bit_tick = o_tick & (r_os == OVERSAMPLE-1). Both are decoded from registers and i_en only; no path from other inputs.
- Reset (i_rst_n low at posedge): active = RESET_DIV/0, r_cnt = RESET_DIV-1, r_acc = 0, r_os = 0, pending cleared; all outputs 0 whenever i_en is 0.
- Priority per cycle: reset > i_en low > i_sync > tick reload > decrement.
- i_en low: r_cnt = div_int-1, r_acc = 0, r_os = 0; a pending divisor is applied immediately and pending clears. i_sync is ignored.
- Decrement: r_cnt != 0 and enabled -> r_cnt - 1.
- Tick reload (r_cnt == 0): {carry, r_acc} = r_acc + div_frac; r_cnt = div_int - 1 + carry; r_os wraps +1. The average period is div_int + frac/2^FRAC_BITS cycles.
- Tick reload uses the pending divisor if one is pending: it replaces active, its int/frac is used for this reload, and pending clears.
- i_sync while enabled: r_cnt = div_int-1, r_acc = 0; r_os = OVERSAMPLE/2 if SYNC_TO_HALF, else 0. A pending divisor is applied and pending clears.
- After sync, the first o_tick is div_int cycles later. The first o_bit_tick falls on the OVERSAMPLE/2-th tick (SYNC_TO_HALF=1) or the OVERSAMPLE-th tick (SYNC_TO_HALF=0).
- i_div_load: captures inputs (clamped) into pending and sets o_div_pending next cycle. A new load overwrites an unapplied one.
- i_div_load in the same cycle as tick reload, sync, or i_en low: the loaded value is applied directly by that event and pending stays 0.
- First tick after i_en rises: o_tick in the div_int-th enabled cycle.

Test Plan:
- Reset, defaults, i_en high from cycle 0 -> o_tick at cycles 26, 53, 80, ...; o_bit_tick first at cycle 431 (16th tick); o_div_pending = 0 throughout.
- Load div_int=3, frac=8 while disabled, then enable -> o_tick intervals repeat 3,4,3,4; 16 ticks span exactly 56 cycles.
- Active div 10; load div 5 in the 4th cycle of a period -> o_div_pending high until the tick 6 cycles later, then low; following intervals are 5.
- Active div 4, OVERSAMPLE 16, pulse i_sync mid-period -> next o_tick 4 cycles after sync; o_bit_tick on the 8th tick (SYNC_TO_HALF=1) or the 16th tick (SYNC_TO_HALF=0).
- Drop i_en mid-period -> o_tick/o_bit_tick low the same cycle; re-enable -> first tick after div_int cycles. Assert i_rst_n low mid-operation with pending set -> pending cleared and RESET_DIV active next cycle.
- Load div_int=0 and div_int=1 -> both clamp; o_tick every 2 cycles, never every cycle.

Source files
------------

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: fractional-divisor oversample tick plus a bit tick
// every OVERSAMPLE oversample ticks. Divisor updates take effect only at period
// boundaries (tick reload, sync, or while disabled). A sync pulse re-phases the
// bit counter so RX can centre its sampling on a detected start bit.
module uart_baud_gen #(
    parameter int CNT_WIDTH    = 16,
    parameter int FRAC_BITS    = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int SYNC_TO_HALF = 1,
    parameter int RESET_DIV    = 27
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_sync,
    input  logic                 i_div_load,
    input  logic [CNT_WIDTH-1:0] i_div_int,
    input  logic [FRAC_BITS-1:0] i_div_frac,
    output logic                 o_tick,
    output logic                 o_bit_tick,
    output logic                 o_div_pending
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_WIDTH-1:0] RESET_INT = CNT_WIDTH'(RESET_DIV);
    localparam logic [CNT_WIDTH-1:0] MIN_DIV   = CNT_WIDTH'(2);
    localparam logic [OS_W-1:0]      OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]      OS_SYNC   = (SYNC_TO_HALF != 0) ? OS_W'(OVERSAMPLE / 2) : '0;

    logic [CNT_WIDTH-1:0] act_int_reg;
    logic [FRAC_BITS-1:0] act_frac_reg;
    logic [CNT_WIDTH-1:0] pend_int_reg;
    logic [FRAC_BITS-1:0] pend_frac_reg;
    logic                 pend_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [FRAC_BITS-1:0] acc_reg;
    logic [OS_W-1:0]      os_reg;

    logic [CNT_WIDTH-1:0] load_int;
    logic [CNT_WIDTH-1:0] sel_int;
    logic [FRAC_BITS-1:0] sel_frac;
    logic [FRAC_BITS:0]   acc_sum;
    logic                 tick_now;

    // Divisor that a period boundary in this cycle would adopt: a same-cycle
    // load wins over an older pending value, which wins over the active one.
    always_comb begin
        load_int = (i_div_int < MIN_DIV) ? MIN_DIV : i_div_int;
        sel_int  = act_int_reg;
        sel_frac = act_frac_reg;
        if (i_div_load) begin
            sel_int  = load_int;
            sel_frac = i_div_frac;
        end else if (pend_reg) begin
            sel_int  = pend_int_reg;
            sel_frac = pend_frac_reg;
        end
        acc_sum = {1'b0, acc_reg} + {1'b0, sel_frac};
    end

    assign tick_now      = (cnt_reg == '0);
    assign o_tick        = i_en & tick_now;
    assign o_bit_tick    = o_tick & (os_reg == OS_LAST);
    assign o_div_pending = i_en & pend_reg;

    // Period counter, fractional accumulator, bit phase and divisor staging.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            act_int_reg   <= RESET_INT;
            act_frac_reg  <= '0;
            pend_int_reg  <= RESET_INT;
            pend_frac_reg <= '0;
            pend_reg      <= 1'b0;
            cnt_reg       <= RESET_INT - CNT_WIDTH'(1);
            acc_reg       <= '0;
            os_reg        <= '0;
        end else if (!i_en || i_sync) begin
            // Disabled or re-phased: restart the period with the newest divisor.
            act_int_reg  <= sel_int;
            act_frac_reg <= sel_frac;
            pend_reg     <= 1'b0;
            cnt_reg      <= sel_int - CNT_WIDTH'(1);
            acc_reg      <= '0;
            os_reg       <= i_en ? OS_SYNC : '0;
        end else if (tick_now) begin
            // Period boundary: stretch by one cycle whenever the fraction carries.
            act_int_reg  <= sel_int;
            act_frac_reg <= sel_frac;
            pend_reg     <= 1'b0;
            cnt_reg      <= sel_int - CNT_WIDTH'(1) + CNT_WIDTH'(acc_sum[FRAC_BITS]);
            acc_reg      <= acc_sum[FRAC_BITS-1:0];
            os_reg       <= os_reg + OS_W'(1);
        end else begin
            cnt_reg <= cnt_reg - CNT_WIDTH'(1);
            if (i_div_load) begin
                pend_int_reg  <= load_int;
                pend_frac_reg <= i_div_frac;
                pend_reg      <= 1'b1;
            end
        end
    end

endmodule
